// File: rtl/enemy_spawn_sched.sv
// -----------------------------------------------------------------------------
// enemy_spawn_sched
//   Decides when and into which of the four enemy slots a tank is spawned.
//   Destroyed tanks wait a respawn cooldown. Free slots are granted round-robin
//   and handed to the tank module with a request/ack handshake. After each
//   accepted spawn there is an idle gap before the next one. Classic mode
//   limits the total number of spawns and reports a win once the budget is
//   used up and the field is empty.
//
//   Optional feature macro: SPAWN_SAFE_EN
//     defined   : no new request is raised while the player sits in the spawn
//                 zone; a request that is already raised is held.
//     undefined : player_in_zone is ignored.
//
// Parameters
//   COOLDOWN_CYC   respawn delay (clk cycles) after a tank is destroyed
//   GAP_CYC        idle cycles between two consecutive spawns
//   CLASSIC_BUDGET total spawns allowed in one classic game
//
// Ports
//   clk                  system clock, rising edge
//   rst_n                asynchronous active-low reset
//   enable_game_classic  classic mode level (wins over infinity)
//   enable_game_infinity infinity mode level
//   destroyed[3:0]       one-cycle hit pulse per slot
//   spawn_ack            tank module accepted the current request
//   player_in_zone       player overlaps the enemy spawn zone
//   spawn_req            spawn request, held until acknowledged
//   spawn_id[1:0]        slot being spawned, valid while spawn_req=1
//   alive[3:0]           per-slot alive flags
//   remaining[7:0]       classic spawns left
//   all_cleared          classic win level
// -----------------------------------------------------------------------------
module enemy_spawn_sched #(
  parameter int unsigned COOLDOWN_CYC   = 100000000,
  parameter int unsigned GAP_CYC        = 5000000,
  parameter int unsigned CLASSIC_BUDGET = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable_game_classic,
  input  logic       enable_game_infinity,
  input  logic [3:0] destroyed,
  input  logic       spawn_ack,
  input  logic       player_in_zone,
  output logic       spawn_req,
  output logic [1:0] spawn_id,
  output logic [3:0] alive,
  output logic [7:0] remaining,
  output logic       all_cleared
);

  // The gap counter holds GAP_CYC-1 down to 0, one count per GUARD cycle.
  localparam int unsigned      GAP_W     = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam logic [GAP_W-1:0] GAP_LOAD  = (GAP_CYC > 0) ? GAP_W'(GAP_CYC - 1) : '0;
  localparam logic [26:0]      COOL_LOAD = 27'(COOLDOWN_CYC);
  localparam logic [7:0]       BUDGET    = 8'(CLASSIC_BUDGET);

  typedef enum logic [1:0] {S_IDLE, S_SELECT, S_REQ, S_GUARD} state_t;

  typedef struct packed {
    logic             spawn_req;
    logic [1:0]       spawn_id;
    logic [1:0]       last_grant;
    logic [3:0]       alive;
    logic [3:0]       pending;
    logic [7:0]       remaining;
    logic [GAP_W-1:0] gap_cnt;
    logic [3:0][26:0] cool;
  } dp_t;

  // NOTE: the per-slot cooldown counters are reset with the rest of the state;
  // a leftover nonzero count would later fire a phantom respawn.
  localparam dp_t DP_RESET = '{
    spawn_req:  1'b0,
    spawn_id:   2'd0,
    last_grant: 2'd3,
    alive:      4'd0,
    pending:    4'd0,
    remaining:  8'd0,
    gap_cnt:    '0,
    cool:       '0
  };

  state_t     r_state;
  state_t     w_state_next;
  dp_t        r_dp;
  logic       w_run;
  logic       w_allowed;
  logic       w_sel_block;
  logic       w_grant_valid;
  logic [1:0] w_grant_id;
  logic       w_do_grant;
  logic       w_do_ack;

  assign w_run     = enable_game_classic | enable_game_infinity;
  // With run high, "not classic" means infinity is the active mode.
  assign w_allowed = !enable_game_classic || (r_dp.remaining != 8'd0);

`ifdef SPAWN_SAFE_EN
  assign w_sel_block = player_in_zone;
`else
  logic w_unused_zone;
  assign w_sel_block   = 1'b0;
  assign w_unused_zone = player_in_zone;
`endif

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // the values from before the edge, whatever order the blocks run in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    // NOTE: each signal of this block gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    w_grant_valid = 1'b0;
    w_grant_id    = r_dp.last_grant;
    w_state_next  = r_state;

    // Walk from the farthest candidate to the nearest one so the slot right
    // after last_grant ends up with the highest priority.
    for (int k = 4; k >= 1; k--) begin
      if (r_dp.pending[2'(r_dp.last_grant + 2'(k))]) begin
        w_grant_valid = 1'b1;
        w_grant_id    = 2'(r_dp.last_grant + 2'(k));
      end
    end

    w_do_grant = (r_state == S_SELECT) && w_grant_valid && !w_sel_block;
    w_do_ack   = (r_state == S_REQ) && spawn_ack;

    unique case (r_state)
      S_IDLE:   w_state_next = S_SELECT;
      S_SELECT: if (w_do_grant) w_state_next = S_REQ;
      S_REQ:    if (w_do_ack) w_state_next = S_GUARD;
      S_GUARD:  if (r_dp.gap_cnt == '0) w_state_next = S_SELECT;
      default:  w_state_next = S_IDLE;
    endcase

    // Leaving the game overrides everything, including an open request.
    if (!w_run) w_state_next = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dp <= DP_RESET;
    end else if (!w_run) begin
      r_dp <= DP_RESET;
    end else if (r_state == S_IDLE) begin
      r_dp.pending   <= 4'hF;
      r_dp.cool      <= '0;
      r_dp.remaining <= enable_game_classic ? BUDGET : 8'd0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (destroyed[i] && r_dp.alive[i]) begin
          r_dp.alive[i] <= 1'b0;
          if (COOLDOWN_CYC == 0) r_dp.pending[i] <= w_allowed;
          else                   r_dp.cool[i]    <= COOL_LOAD;
        end else if (r_dp.cool[i] == 27'd1) begin
          // Cooldown expires: the slot comes back only while spawns remain.
          r_dp.cool[i]    <= '0;
          r_dp.pending[i] <= w_allowed;
        end else if (r_dp.cool[i] != '0) begin
          r_dp.cool[i] <= r_dp.cool[i] - 27'd1;
        end
      end

      if (r_state == S_GUARD && r_dp.gap_cnt != '0) begin
        r_dp.gap_cnt <= r_dp.gap_cnt - GAP_W'(1);
      end

      if (w_do_ack) begin
        r_dp.alive[r_dp.spawn_id]   <= 1'b1;
        r_dp.pending[r_dp.spawn_id] <= 1'b0;
        r_dp.last_grant             <= r_dp.spawn_id;
        r_dp.spawn_req              <= 1'b0;
        r_dp.gap_cnt                <= GAP_LOAD;
        if (enable_game_classic && r_dp.remaining != 8'd0) begin
          r_dp.remaining <= r_dp.remaining - 8'd1;
        end
      end

      if (w_do_grant) begin
        r_dp.spawn_req <= 1'b1;
        r_dp.spawn_id  <= w_grant_id;
      end
    end
  end

  assign spawn_req   = r_dp.spawn_req;
  assign spawn_id    = r_dp.spawn_id;
  assign alive       = r_dp.alive;
  assign remaining   = r_dp.remaining;
  assign all_cleared = enable_game_classic && (r_state != S_IDLE) &&
                       (r_dp.remaining == 8'd0) && (r_dp.alive == 4'd0) &&
                       (r_dp.pending == 4'd0);

endmodule

// File: tb/tb_enemy_spawn_sched.sv
// -----------------------------------------------------------------------------
// tb_enemy_spawn_sched
//   Directed bench for enemy_spawn_sched with a small timestamp-based model of
//   the spawn rules, compared against the DUT on every falling clock edge, plus
//   hand-computed expectations for the key scenarios. Build with or without
//   SPAWN_SAFE_EN; the model and the safe-zone expectations follow the macro.
// -----------------------------------------------------------------------------
module tb_enemy_spawn_sched;

  localparam int COOL   = 10;
  localparam int GAP    = 4;
  localparam int BUDGET = 20;
`ifdef SPAWN_SAFE_EN
  localparam bit SAFE = 1'b1;
`else
  localparam bit SAFE = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       enable_game_classic = 1'b0;
  logic       enable_game_infinity = 1'b0;
  logic [3:0] destroyed = 4'd0;
  logic       spawn_ack = 1'b0;
  logic       player_in_zone = 1'b0;
  logic       spawn_req;
  logic [1:0] spawn_id;
  logic [3:0] alive;
  logic [7:0] remaining;
  logic       all_cleared;

  always #5 clk = ~clk;

  enemy_spawn_sched #(
    .COOLDOWN_CYC  (COOL),
    .GAP_CYC       (GAP),
    .CLASSIC_BUDGET(BUDGET)
  ) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .enable_game_classic (enable_game_classic),
    .enable_game_infinity(enable_game_infinity),
    .destroyed           (destroyed),
    .spawn_ack           (spawn_ack),
    .player_in_zone      (player_in_zone),
    .spawn_req           (spawn_req),
    .spawn_id            (spawn_id),
    .alive               (alive),
    .remaining           (remaining),
    .all_cleared         (all_cleared)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Model: game-level view. Respawns and the end of the inter-spawn gap are
  // kept as absolute edge numbers rather than counters.
  // ---------------------------------------------------------------------------
  int         cyc = 0;
  bit         m_active = 1'b0;
  bit         m_req = 1'b0;
  logic [1:0] m_id = 2'd0;
  logic [1:0] m_last = 2'd3;
  logic [3:0] m_alive = 4'd0;
  logic [3:0] m_pend = 4'd0;
  int         m_rem = 0;
  int         m_sel_from = 0;
  int         m_resp [4] = '{-1, -1, -1, -1};

  task automatic model_clear();
    m_active   = 1'b0;
    m_req      = 1'b0;
    m_id       = 2'd0;
    m_last     = 2'd3;
    m_alive    = 4'd0;
    m_pend     = 4'd0;
    m_rem      = 0;
    m_sel_from = 0;
    for (int i = 0; i < 4; i++) m_resp[i] = -1;
  endtask

  task automatic model_step();
    logic [3:0] old_pend;
    bit         allowed;
    int         idx;
    if (!(enable_game_classic || enable_game_infinity)) begin
      model_clear();
      return;
    end
    if (!m_active) begin
      m_active   = 1'b1;
      m_pend     = 4'hF;
      m_rem      = enable_game_classic ? BUDGET : 0;
      m_sel_from = cyc + 1;
      for (int i = 0; i < 4; i++) m_resp[i] = -1;
      return;
    end
    old_pend = m_pend;
    allowed  = !enable_game_classic || (m_rem > 0);
    for (int i = 0; i < 4; i++) begin
      if (m_resp[i] == cyc) begin
        m_pend[i] = allowed;
        m_resp[i] = -1;
      end else if (destroyed[i] && m_alive[i]) begin
        m_alive[i] = 1'b0;
        m_resp[i]  = cyc + COOL;
      end
    end
    if (m_req) begin
      if (spawn_ack) begin
        m_alive[m_id] = 1'b1;
        m_pend[m_id]  = 1'b0;
        if (enable_game_classic && m_rem > 0) m_rem--;
        m_last     = m_id;
        m_req      = 1'b0;
        m_sel_from = cyc + GAP + 1;
      end
    end else if (cyc >= m_sel_from && old_pend != 4'd0 && !(SAFE && player_in_zone)) begin
      for (int off = 1; off <= 4; off++) begin
        idx = (m_last + off) % 4;
        if (old_pend[idx]) begin
          m_id  = 2'(idx);
          m_req = 1'b1;
          break;
        end
      end
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      model_clear();
    end else begin
      cyc++;
      model_step();
    end
  end

  always @(negedge clk) begin
    check("cmp_spawn_req", spawn_req, m_req);
    if (m_req) check("cmp_spawn_id", spawn_id, m_id);
    check("cmp_alive", alive, m_alive);
    check("cmp_remaining", remaining, m_rem);
    check("cmp_all_cleared", all_cleared,
          m_active && enable_game_classic && m_rem == 0 && m_alive == 4'd0 && m_pend == 4'd0);
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers: inputs change 1 time unit after the rising edge.
  // ---------------------------------------------------------------------------
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Waits for spawn_req to be seen high; e is the edge number that raised it.
  task automatic wait_rise(input string name, input int limit, output int e);
    e = -1;
    for (int k = 0; k < limit; k++) begin
      tick();
      if (spawn_req) begin
        e = cyc;
        return;
      end
    end
    checks++;
    failures++;
    $display("FAIL %s: no spawn_req within %0d cycles", name, limit);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not reach its summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int e;
    int prev;
    int t0;
    int hi;

    #1 rst_n = 1'b0;
    tick(3);
    check("reset_spawn_req", spawn_req, 0);
    check("reset_alive", alive, 0);
    check("reset_remaining", remaining, 0);
    check("reset_all_cleared", all_cleared, 0);
    rst_n = 1'b1;
    tick(3);
    check("idle_no_req", spawn_req, 0);

    // Classic start, ack tied high: slots 0..3 at 6-edge spacing (1 req + 4 gap + 1 select).
    spawn_ack = 1'b1;
    enable_game_classic = 1'b1;
    t0 = cyc;
    prev = 0;
    for (int n = 0; n < 4; n++) begin
      wait_rise("classic_start", 20, e);
      check("start_spawn_id", spawn_id, n);
      if (n == 0) check("start_latency", e - t0, 2);
      else        check("start_spacing", e - prev, GAP + 2);
      prev = e;
    end
    tick(2);
    check("start_alive", alive, 4'hF);
    check("start_remaining", remaining, BUDGET - 4);

    // Slot 2 destroyed: requested again COOL edges later plus one select edge.
    tick(6);
    destroyed = 4'b0100;
    tick();
    t0 = cyc;
    destroyed = 4'd0;
    check("destroy_alive", alive, 4'b1011);
    wait_rise("respawn", 30, e);
    check("respawn_delay", e - t0, COOL + 1);
    check("respawn_id", spawn_id, 2);
    tick(2);
    check("respawn_alive", alive, 4'hF);
    check("respawn_remaining", remaining, BUDGET - 5);

    // Spend the budget exactly: 3 more, then three full rounds of 4.
    tick(6);
    destroyed = 4'b0111;
    tick();
    destroyed = 4'd0;
    tick(40);
    check("round_remaining", remaining, 12);
    for (int r = 0; r < 3; r++) begin
      destroyed = 4'hF;
      tick();
      destroyed = 4'd0;
      tick(45);
    end
    check("budget_spent", remaining, 0);
    check("budget_alive", alive, 4'hF);
    check("not_cleared_yet", all_cleared, 0);
    destroyed = 4'hF;
    tick();
    destroyed = 4'd0;
    hi = 0;
    repeat (40) begin
      tick();
      if (spawn_req) hi++;
    end
    check("no_spawn_after_budget", hi, 0);
    check("cleared_alive", alive, 0);
    check("all_cleared", all_cleared, 1);

    // Leave classic; infinity with ack withheld for 50 cycles.
    enable_game_classic = 1'b0;
    tick();
    check("idle_remaining", remaining, 0);
    check("idle_cleared", all_cleared, 0);
    spawn_ack = 1'b0;
    enable_game_infinity = 1'b1;
    wait_rise("inf_start", 10, e);
    hi = 0;
    repeat (50) begin
      tick();
      if (spawn_req && spawn_id == 2'd0) hi++;
    end
    check("held_req_cycles", hi, 50);
    check("inf_remaining", remaining, 0);
    enable_game_infinity = 1'b0;
    tick();
    check("drop_run_req", spawn_req, 0);
    check("drop_run_alive", alive, 0);

    // Infinity: destroy on slot 3 in the same edge as the ack for slot 0.
    enable_game_infinity = 1'b1;
    spawn_ack = 1'b1;
    tick(30);
    check("inf_alive", alive, 4'hF);
    spawn_ack = 1'b0;
    destroyed = 4'b0001;
    tick();
    destroyed = 4'd0;
    wait_rise("inf_respawn", 30, e);
    check("inf_respawn_id", spawn_id, 0);
    spawn_ack = 1'b1;
    destroyed = 4'b1000;
    tick();
    destroyed = 4'd0;
    check("simul_alive", alive, 4'b0111);
    tick(40);
    check("simul_recovered", alive, 4'hF);

    // A raised request is held while the player enters the zone.
    spawn_ack = 1'b0;
    destroyed = 4'b0010;
    tick();
    destroyed = 4'd0;
    wait_rise("zone_hold", 30, e);
    player_in_zone = 1'b1;
    tick(5);
    check("zone_hold_req", spawn_req, 1);
    check("zone_hold_id", spawn_id, 1);
    player_in_zone = 1'b0;
    spawn_ack = 1'b1;
    tick(10);

    // Player in the zone for 100 cycles from a fresh start.
    enable_game_infinity = 1'b0;
    tick(2);
    player_in_zone = 1'b1;
    enable_game_infinity = 1'b1;
    hi = 0;
    repeat (100) begin
      tick();
      if (spawn_req) hi++;
    end
    player_in_zone = 1'b0;
    t0 = cyc;
`ifdef SPAWN_SAFE_EN
    check("safe_no_req", hi, 0);
    wait_rise("safe_first", 10, e);
    check("safe_first_latency", e - t0, 1);
    check("safe_first_id", spawn_id, 0);
`else
    check("zone_ignored", hi != 0, 1);
`endif
    tick(30);

    // Asynchronous reset in the middle of GUARD during a classic game.
    enable_game_infinity = 1'b0;
    tick(2);
    enable_game_classic = 1'b1;
    wait_rise("guard_setup", 10, e);
    tick(2);
    #2;
    check("pre_reset_alive", alive, 4'b0001);
    check("pre_reset_remaining", remaining, BUDGET - 1);
    rst_n = 1'b0;
    #1;
    check("async_spawn_req", spawn_req, 0);
    check("async_spawn_id", spawn_id, 0);
    check("async_alive", alive, 0);
    check("async_remaining", remaining, 0);
    check("async_all_cleared", all_cleared, 0);
    tick(2);
    rst_n = 1'b1;

    // Both modes high: classic wins, so the budget is loaded.
    enable_game_infinity = 1'b1;
    tick(2);
    check("precedence_remaining", remaining, BUDGET);
    check("precedence_req", spawn_req, 1);
    enable_game_classic = 1'b0;
    enable_game_infinity = 1'b0;
    tick(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/enemy_spawn_sched.md
ENEMY_SPAWN_SCHED -- requirements
Module: enemy_spawn_sched

Interface
REQ-001 Parameter COOLDOWN_CYC, default 100000000, respawn delay in clk cycles after a tank is destroyed (27-bit counter).
REQ-002 Parameter GAP_CYC, default 5000000, minimum idle cycles between two consecutive spawns.
REQ-003 Parameter CLASSIC_BUDGET, default 20, total enemy spawns allowed per classic game (8-bit).
REQ-004 clk  input  1  system clock; all state is updated on the rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 enable_game_classic  input  1  classic-mode enable level from the game mode controller.
REQ-007 enable_game_infinity  input  1  infinity-mode enable level from the game mode controller.
REQ-008 destroyed  input  4  one-cycle pulse per enemy slot i; slot i was hit.
REQ-009 spawn_ack  input  1  tank module accepted the current spawn request.
REQ-010 player_in_zone  input  1  player tank overlaps the enemy spawn zone.
REQ-011 spawn_req  output  1  spawn request, held until acknowledged.
REQ-012 spawn_id  output  2  slot being spawned; valid while spawn_req=1.
REQ-013 alive  output  4  per-slot enemy tank alive flags.
REQ-014 remaining  output  8  classic spawns left.
REQ-015 all_cleared  output  1  classic win level.

Function
REQ-016 The block SHALL treat run = enable_game_classic | enable_game_infinity; classic takes precedence when both are high.
REQ-017 While run=0, the block SHALL hold state IDLE and all outputs, cooldowns and pending flags at their reset values; remaining SHALL read 0.
REQ-018 On IDLE with run=1, the block SHALL mark all 4 slots pending with zero cooldown, load remaining=CLASSIC_BUDGET in classic mode, and enter SELECT next cycle.
REQ-019 A destroyed[i] pulse while alive[i]=1 SHALL clear alive[i] and load cooldown[i]=COOLDOWN_CYC; pulses on non-alive slots SHALL be ignored.
REQ-020 A nonzero cooldown[i] SHALL decrement by 1 per cycle; at 0, slot i SHALL become pending only if infinity mode is active or remaining>0.
REQ-021 SELECT SHALL grant round-robin among pending slots, searching from last_grant+1 upward with wrap 3->0; last_grant resets to 3, so slot 0 wins first.
REQ-022 On a grant, the block SHALL enter REQ the following cycle with spawn_req=1 and spawn_id=granted slot, both held stable until spawn_ack=1.
REQ-023 In REQ, a cycle with spawn_ack=1 SHALL set alive[id], clear pending[id], decrement remaining (classic only, saturating at 0), update last_grant, deassert spawn_req next cycle, and enter GUARD.
REQ-024 GUARD SHALL last exactly GAP_CYC cycles and then return to SELECT; SELECT with no pending slot SHALL stay in SELECT.
REQ-025 Simultaneous destroyed pulses on several slots, or destroyed together with spawn_ack on a different slot, SHALL all be applied in the same cycle.
REQ-026 spawn_ack outside REQ SHALL be ignored.
REQ-027 run falling in any state, including REQ, SHALL return to IDLE next cycle with spawn_req=0 and no alive or remaining update.
REQ-028 all_cleared SHALL be 1 exactly when classic is active, remaining=0, alive=0, no slot is pending, and state is not IDLE.

Reset
REQ-029 rst_n=0 SHALL asynchronously force state=IDLE, spawn_req=0, spawn_id=0, alive=0, remaining=0, all_cleared=0, all cooldowns=0, pending=0 and last_grant=3.
REQ-030 After rst_n rises, the first action SHALL occur on the first clk edge with run=1.

Configuration
REQ-031 With SPAWN_SAFE_EN defined, SELECT SHALL not grant while player_in_zone=1, and spawn_req SHALL never rise while player_in_zone=1; a request already in REQ SHALL be held.
REQ-032 Without SPAWN_SAFE_EN, player_in_zone SHALL be ignored.

Verification
REQ-033 Classic start with ack tied to 1 and GAP_CYC=4 -> spawn_id sequence 0,1,2,3 with 4-cycle gaps; alive=4'hF; remaining=16.
REQ-034 COOLDOWN_CYC=10, destroyed=4'b0100 pulse -> alive[2]=0, and slot 2 is requested exactly 10 cycles later plus SELECT latency.
REQ-035 CLASSIC_BUDGET=4, all four tanks destroyed after spawning -> no further spawn_req; all_cleared=1 once alive=0.
REQ-036 Infinity mode with ack withheld 50 cycles -> spawn_req and spawn_id stable for 50 cycles; dropping run mid-request -> spawn_req=0 next cycle and state IDLE.
REQ-037 SPAWN_SAFE_EN build with player_in_zone=1 for 100 cycles -> no spawn_req; the first request comes one cycle after player_in_zone falls.
REQ-038 Assert rst_n=0 mid-GUARD -> all outputs are 0 immediately, without waiting for a clk edge.
